// File: rtl/ldpc_frame_adapter_if.sv
// Decoder-core handshake bundle used by ldpc_frame_adapter (adapter = master, core = slave).
// Optional SOFT_LLR_EN widens dec_in_data to a 3-bit LLR per hard bit.
interface ldpc_frame_adapter_if #(
  parameter int SYM_BITS = 2
);
`ifdef SOFT_LLR_EN
  localparam int LLR_W = 3;
`else
  localparam int LLR_W = 1;
`endif
  localparam int DIN_W = SYM_BITS * LLR_W;

  logic                dec_in_sop;
  logic                dec_in_eop;
  logic                dec_in_valid;
  logic                dec_in_ready;
  logic [DIN_W-1:0]    dec_in_data;
  logic                dec_out_sop;
  logic                dec_out_eop;
  logic                dec_out_valid;
  logic [SYM_BITS-1:0] dec_out_data;
  logic                dec_out_ready;

  modport master (
    output dec_in_sop, dec_in_eop, dec_in_valid, dec_in_data, dec_out_ready,
    input  dec_in_ready, dec_out_sop, dec_out_eop, dec_out_valid, dec_out_data
  );

  modport slave (
    input  dec_in_sop, dec_in_eop, dec_in_valid, dec_in_data, dec_out_ready,
    output dec_in_ready, dec_out_sop, dec_out_eop, dec_out_valid, dec_out_data
  );
endinterface

// File: rtl/ldpc_frame_adapter.sv
// Byte-stream <-> LDPC core adapter: collect codeword, feed core beats, repack decoded bits, reset core.
// Define SOFT_LLR_EN to drive 3-bit LLRs {b,2'b11} per bit instead of raw hard bits.
module ldpc_frame_adapter #(
  parameter int CW_BITS       = 1200,
  parameter int SYM_BITS      = 2,
  parameter int OUT_W         = 32,
  parameter int CLK1X_DIV     = 50,
  parameter int TIMEOUT_TICKS = 1230,
  parameter int RST_HOLD      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  ldpc_frame_adapter_if.master dec,
  output logic [7:0]           byte_out,
  output logic                 byte_out_valid,
  output logic [OUT_W-1:0]     word_out,
  output logic                 word_out_valid,
  output logic                 core_rst_n,
  output logic                 frame_err,
  output logic                 overrun
);
`ifdef SOFT_LLR_EN
  localparam int LLR_W = 3;
`else
  localparam int LLR_W = 1;
`endif
  localparam int DIN_W  = SYM_BITS * LLR_W;
  localparam int NBYTES = (CW_BITS + 7) / 8;
  localparam int NBEATS = CW_BITS / SYM_BITS;
  localparam int NW     = OUT_W / 8;
  localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int N_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int P_W    = $clog2(CW_BITS + 9);
  localparam int TMR_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int DIV_W  = $clog2(CLK1X_DIV + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int WC_W   = $clog2(NW + 1);
  localparam int SYM_SH = $clog2(SYM_BITS);

  localparam logic [P_W-1:0]    CW_P      = P_W'(CW_BITS);
  localparam logic [N_W-1:0]    LAST_N    = N_W'(NBEATS - 1);
  localparam logic [TMR_W-1:0]  TMO_T     = TMR_W'(TIMEOUT_TICKS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK1X_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [WC_W-1:0]   NW_LAST   = WC_W'(NW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_FEED, S_WAIT_OUT, S_FLUSH
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q;
  logic                rise;
  logic [7:0]          mem_q [NBYTES];
  logic [P_W-1:0]      p_q;
  logic [DIV_W-1:0]    div_q;
  logic                tick;
  logic [TMR_W-1:0]    timer_q;
  logic [N_W-1:0]      n_q;
  logic [HOLD_W-1:0]   hold_q;

  logic                wr_en, p_clr, tmr_clr, beat_acc, err_d, ovr_d;
  logic [BI_W-1:0]     wr_idx, rd_idx;
  logic [N_W+2:0]      bit_addr;
  logic [7:0]          rd_byte;
  logic [SYM_BITS-1:0] beat_bits;
  logic [DIN_W-1:0]    din;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = d[i];
    return r;
  endfunction

  function automatic logic [SYM_BITS-1:0] rev_sym(input logic [SYM_BITS-1:0] d);
    logic [SYM_BITS-1:0] r;
    for (int i = 0; i < SYM_BITS; i++) r[SYM_BITS-1-i] = d[i];
    return r;
  endfunction

  assign rise   = byte_valid & ~valid_q;
  assign tick   = (div_q == DIV_LAST);
  assign wr_idx = BI_W'(p_q >> 3);

  // Bytes are stored bit-reversed so buffer bit k sits at mem[k/8][k%8]; a beat never straddles a byte.
  assign bit_addr  = (N_W + 3)'(n_q) << SYM_SH;
  assign rd_idx    = BI_W'(bit_addr >> 3);
  assign rd_byte   = mem_q[rd_idx];
  assign beat_bits = SYM_BITS'(rd_byte >> bit_addr[2:0]);

`ifdef SOFT_LLR_EN
  always_comb begin
    din = '0;
    for (int j = 0; j < SYM_BITS; j++) din[3*j +: 3] = {beat_bits[j], 2'b11};
  end
`else
  assign din = beat_bits;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    p_clr    = 1'b0;
    tmr_clr  = 1'b0;
    beat_acc = 1'b0;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          wr_en   = 1'b1;
          tmr_clr = 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (p_q >= CW_P) begin
          state_d = S_FEED;
        end else if (timer_q == TMO_T) begin
          err_d   = 1'b1;
          p_clr   = 1'b1;
          state_d = S_IDLE;
        end else if (rise) begin
          wr_en = 1'b1;
        end
      end
      S_FEED: begin
        ovr_d = rise;
        if (dec.dec_in_ready) begin
          beat_acc = 1'b1;
          if (n_q == LAST_N) state_d = S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        ovr_d = rise;
        if (dec.dec_out_valid && dec.dec_out_eop) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        ovr_d = rise;
        if (hold_q == HOLD_LAST) begin
          p_clr   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      p_q       <= '0;
      div_q     <= '0;
      timer_q   <= '0;
      n_q       <= '0;
      hold_q    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // NOTE: the codeword buffer is reset too, so an aborted frame leaves no stale bits behind.
      for (int i = 0; i < NBYTES; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= byte_valid;
      frame_err <= err_d;
      overrun   <= ovr_d;
      div_q     <= tick ? '0 : div_q + DIV_W'(1);
      if (p_clr) begin
        p_q <= '0;
      end else if (wr_en) begin
        mem_q[wr_idx] <= rev8(byte_data);
        p_q           <= p_q + P_W'(8);
      end
      if (tmr_clr)                         timer_q <= '0;
      else if (state_q == S_COLLECT && tick) timer_q <= timer_q + TMR_W'(1);
      if (beat_acc) n_q <= (n_q == LAST_N) ? '0 : n_q + N_W'(1);
      hold_q <= (state_q == S_FLUSH) ? hold_q + HOLD_W'(1) : '0;
    end
  end

  assign dec.dec_in_valid  = (state_q == S_FEED);
  assign dec.dec_in_sop    = (state_q == S_FEED) && (n_q == '0);
  assign dec.dec_in_eop    = (state_q == S_FEED) && (n_q == LAST_N);
  assign dec.dec_in_data   = (state_q == S_FEED) ? din : '0;
  assign dec.dec_out_ready = 1'b1;
  assign core_rst_n        = rst_n & (state_q != S_FLUSH);

  // Repack: decoded bits enter at the byte LSB so the earliest bit ends up as the MSB.
  logic [3:0]       bit_cnt_q, cnt_base, cnt_new;
  logic [7:0]       pack_q, byte_base, byte_new, byte_fill;
  logic [WC_W-1:0]  wcnt_q, wcnt_base;
  logic [OUT_W-1:0] wacc_q, word_base, word_new;
  logic             byte_done, word_done;

  always_comb begin
    cnt_base  = dec.dec_out_sop ? '0 : bit_cnt_q;
    byte_base = dec.dec_out_sop ? '0 : pack_q;
    wcnt_base = dec.dec_out_sop ? '0 : wcnt_q;
    word_base = dec.dec_out_sop ? '0 : wacc_q;
    byte_new  = (byte_base << SYM_BITS) | 8'(rev_sym(dec.dec_out_data));
    cnt_new   = cnt_base + 4'(SYM_BITS);
    byte_fill = byte_new << (4'd8 - cnt_new);
    word_new  = word_base | (OUT_W'(byte_fill) << {wcnt_base, 3'b000});
    byte_done = (cnt_new == 4'd8) || dec.dec_out_eop;
    word_done = (wcnt_base == NW_LAST) || dec.dec_out_eop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q      <= '0;
      pack_q         <= '0;
      wcnt_q         <= '0;
      wacc_q         <= '0;
      byte_out       <= '0;
      byte_out_valid <= 1'b0;
      word_out       <= '0;
      word_out_valid <= 1'b0;
    end else begin
      byte_out_valid <= 1'b0;
      word_out_valid <= 1'b0;
      if (dec.dec_out_valid) begin
        if (byte_done) begin
          byte_out       <= byte_fill;
          byte_out_valid <= 1'b1;
          bit_cnt_q      <= '0;
          pack_q         <= '0;
          if (word_done) begin
            word_out       <= word_new;
            word_out_valid <= 1'b1;
            wcnt_q         <= '0;
            wacc_q         <= '0;
          end else begin
            wcnt_q <= wcnt_base + WC_W'(1);
            wacc_q <= word_new;
          end
        end else begin
          bit_cnt_q <= cnt_new;
          pack_q    <= byte_new;
          wcnt_q    <= wcnt_base;
          wacc_q    <= word_base;
        end
      end
    end
  end
endmodule

// File: tb/tb_ldpc_frame_adapter.sv
// Randomized self-checking bench for ldpc_frame_adapter against a bit-list reference model.
// Handles both the default build and SOFT_LLR_EN.
module tb_ldpc_frame_adapter;
  localparam int CW    = 1200;
  localparam int SYM   = 2;
  localparam int OUT_W = 32;
  localparam int DIV   = 50;
  localparam int TO    = 1230;
  localparam int HOLD  = 16;
  localparam int NB    = CW / 8;
  localparam int NBEAT = CW / SYM;
  localparam int NW    = OUT_W / 8;
`ifdef SOFT_LLR_EN
  localparam int DIN_W = SYM * 3;
`else
  localparam int DIN_W = SYM;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic [7:0]       byte_out;
  logic             byte_out_valid;
  logic [OUT_W-1:0] word_out;
  logic             word_out_valid;
  logic             core_rst_n;
  logic             frame_err;
  logic             overrun;

  ldpc_frame_adapter_if #(.SYM_BITS(SYM)) dec_if ();

  ldpc_frame_adapter #(
    .CW_BITS(CW), .SYM_BITS(SYM), .OUT_W(OUT_W),
    .CLK1X_DIV(DIV), .TIMEOUT_TICKS(TO), .RST_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .dec(dec_if), .byte_out(byte_out), .byte_out_valid(byte_out_valid),
    .word_out(word_out), .word_out_valid(word_out_valid), .core_rst_n(core_rst_n),
    .frame_err(frame_err), .overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int cyc = 0;
  int valid_cycles = 0, stall_cmp = 0, stall_bad = 0;
  int err_cnt = 0, err_cyc = 0, ovr_cnt = 0, core_low = 0;
  logic             prev_stall = 1'b0;
  logic [DIN_W+1:0] prev_beat;
  logic [DIN_W+1:0] beats_q[$];
  logic [7:0]       obytes_q[$];
  logic [OUT_W-1:0] owords_q[$];
  int               ready_mode = 1;

  // Reference data
  logic [7:0]     frame_bytes[$];
  logic [SYM-1:0] dec_beats[$];
  logic           dec_bits[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (dec_if.dec_in_valid) begin
        valid_cycles++;
        if (prev_stall) begin
          stall_cmp++;
          if ({dec_if.dec_in_sop, dec_if.dec_in_eop, dec_if.dec_in_data} !== prev_beat) stall_bad++;
        end
        if (dec_if.dec_in_ready)
          beats_q.push_back({dec_if.dec_in_sop, dec_if.dec_in_eop, dec_if.dec_in_data});
        prev_stall = !dec_if.dec_in_ready;
        prev_beat  = {dec_if.dec_in_sop, dec_if.dec_in_eop, dec_if.dec_in_data};
      end else begin
        prev_stall = 1'b0;
      end
      if (byte_out_valid) obytes_q.push_back(byte_out);
      if (word_out_valid) owords_q.push_back(word_out);
      if (frame_err) begin err_cnt++; err_cyc = cyc; end
      if (overrun) ovr_cnt++;
      if (!core_rst_n) core_low++;
    end
  end

  initial begin
    dec_if.dec_in_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       dec_if.dec_in_ready = 1'b0;
        1:       dec_if.dec_in_ready = 1'b1;
        2:       dec_if.dec_in_ready = ~dec_if.dec_in_ready;
        default: dec_if.dec_in_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic logic [DIN_W-1:0] map_beat(input logic [SYM-1:0] b);
    logic [DIN_W-1:0] r;
`ifdef SOFT_LLR_EN
    for (int j = 0; j < SYM; j++) r[3*j +: 3] = {b[j], 2'b11};
`else
    r = b;
`endif
    return r;
  endfunction

  // Codeword bit k is bit (7 - k%8) of received byte k/8; beat n carries bits n*SYM.. (lsb earliest).
  function automatic logic [SYM-1:0] model_beat(input int n);
    logic [SYM-1:0] b;
    logic [7:0]     by;
    for (int j = 0; j < SYM; j++) begin
      int k;
      k    = n * SYM + j;
      by   = frame_bytes[k / 8];
      b[j] = by[7 - (k % 8)];
    end
    return b;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic random_frame();
    frame_bytes.delete();
    for (int i = 0; i < NB; i++) frame_bytes.push_back(8'($urandom));
  endtask

  task automatic wait_beats(input int n, input string tag);
    int c;
    c = 0;
    while (beats_q.size() < n && c < 8000) begin
      @(posedge clk);
      c++;
    end
    #1;
    check({tag, "_feed_done"}, 64'(beats_q.size() >= n), 64'd1);
  endtask

  task automatic run_feed(input string tag);
    beats_q.delete();
    foreach (frame_bytes[i]) send_byte(frame_bytes[i]);
    wait_beats(NBEAT, tag);
    cycles(6);
    check({tag, "_beat_count"}, 64'(beats_q.size()), 64'(NBEAT));
    check({tag, "_valid_idle"}, 64'(dec_if.dec_in_valid), 64'd0);
    for (int n = 0; n < NBEAT && n < beats_q.size(); n++)
      check($sformatf("%s_beat%0d", tag, n), 64'(beats_q[n]),
            64'({n == 0, n == NBEAT - 1, map_beat(model_beat(n))}));
  endtask

  task automatic send_decoded(input bit with_eop);
    logic [SYM-1:0] bt;
    dec_bits.delete();
    obytes_q.delete();
    owords_q.delete();
    for (int i = 0; i < dec_beats.size(); i++) begin
      @(posedge clk); #1;
      bt = dec_beats[i];
      dec_if.dec_out_valid = 1'b1;
      dec_if.dec_out_data  = bt;
      dec_if.dec_out_sop   = (i == 0);
      dec_if.dec_out_eop   = with_eop && (i == dec_beats.size() - 1);
      for (int j = 0; j < SYM; j++) dec_bits.push_back(bt[j]);
    end
    @(posedge clk); #1;
    dec_if.dec_out_valid = 1'b0;
    dec_if.dec_out_sop   = 1'b0;
    dec_if.dec_out_eop   = 1'b0;
    dec_if.dec_out_data  = '0;
    cycles(3);
  endtask

  // Bytes: 8 bits each, earliest bit as MSB, last one zero-filled; words: NW bytes, byte 0 in [7:0].
  task automatic check_pack(input string tag);
    int nbits, nbytes, nwords;
    logic [7:0]       eb[$];
    logic [7:0]       b;
    logic [OUT_W-1:0] w;
    nbits  = dec_bits.size();
    nbytes = (nbits + 7) / 8;
    nwords = (nbytes + NW - 1) / NW;
    check({tag, "_nbytes"}, 64'(obytes_q.size()), 64'(nbytes));
    check({tag, "_nwords"}, 64'(owords_q.size()), 64'(nwords));
    for (int i = 0; i < nbytes; i++) begin
      b = '0;
      for (int t = 0; t < 8; t++) if (8 * i + t < nbits) b[7 - t] = dec_bits[8 * i + t];
      eb.push_back(b);
      if (i < obytes_q.size()) check($sformatf("%s_byte%0d", tag, i), 64'(obytes_q[i]), 64'(b));
    end
    for (int wi = 0; wi < nwords; wi++) begin
      w = '0;
      for (int k = 0; k < NW; k++) if (wi * NW + k < nbytes) w[8 * k +: 8] = eb[wi * NW + k];
      if (wi < owords_q.size()) check($sformatf("%s_word%0d", tag, wi), 64'(owords_q[wi]), 64'(w));
    end
  endtask

  task automatic finish_frame(input string tag, input int low0);
    cycles(HOLD + 8);
    check({tag, "_core_rst_low"}, 64'(core_low - low0), 64'(HOLD));
    check({tag, "_core_rst_back"}, 64'(core_rst_n), 64'd1);
  endtask

  initial begin
    int v0, e0, o0, s0, low0, t0, d, c;
    rst_n = 1'b0;
    byte_valid = 1'b0;
    byte_data = '0;
    dec_if.dec_out_valid = 1'b0;
    dec_if.dec_out_sop = 1'b0;
    dec_if.dec_out_eop = 1'b0;
    dec_if.dec_out_data = '0;
    cycles(3);

    check("rst_in_valid", 64'(dec_if.dec_in_valid), 64'd0);
    check("rst_in_sop", 64'(dec_if.dec_in_sop), 64'd0);
    check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check("rst_out_ready", 64'(dec_if.dec_out_ready), 64'd1);
    check("rst_word_out", 64'(word_out), 64'd0);
    check("rst_flags", 64'({frame_err, overrun, byte_out_valid, word_out_valid}), 64'd0);
    rst_n = 1'b1;
    cycles(3);
    check("idle_core_rst_n", 64'(core_rst_n), 64'd1);

    // Frame of 0xA5 with an always-ready core, decoded 0x87 pattern.
    frame_bytes.delete();
    repeat (NB) frame_bytes.push_back(8'hA5);
    ready_mode = 1;
    e0 = err_cnt;
    run_feed("t1");
    check("t1_beat0_sop", 64'(beats_q[0]), 64'({1'b1, 1'b0, map_beat(2'b01)}));
    check("t1_no_frame_err", 64'(err_cnt - e0), 64'd0);
    dec_beats.delete();
    repeat (4) begin
      dec_beats.push_back(2'b01); dec_beats.push_back(2'b00);
      dec_beats.push_back(2'b10); dec_beats.push_back(2'b11);
    end
    low0 = core_low;
    send_decoded(1'b1);
    check_pack("t1");
    if (obytes_q.size() > 0) check("t1_byte_0x87", 64'(obytes_q[0]), 64'h87);
    if (owords_q.size() > 0) check("t1_word_0x87", 64'(owords_q[0]), 64'h87878787);
    finish_frame("t1", low0);

    // Partial frame: timeout after TO ticks, core never sees a beat.
    random_frame();
    v0 = valid_cycles;
    e0 = err_cnt;
    send_byte(frame_bytes[0]);
    t0 = cyc;
    for (int i = 1; i < 10; i++) send_byte(frame_bytes[i]);
    c = 0;
    while (err_cnt == e0 && c < (TO + 2) * DIV) begin
      @(posedge clk);
      c++;
    end
    cycles(2);
    d = err_cyc - t0;
    check("t3_frame_err_once", 64'(err_cnt - e0), 64'd1);
    check("t3_err_time_window", 64'(d >= (TO - 1) * DIV && d <= (TO + 1) * DIV), 64'd1);
    check("t3_no_valid", 64'(valid_cycles - v0), 64'd0);

    // Next frame after timeout: random data, ready toggling 1010.
    random_frame();
    ready_mode = 2;
    s0 = stall_cmp;
    run_feed("t2");
    ready_mode = 1;
    check("t2_stalls_seen", 64'(stall_cmp > s0), 64'd1);
    check("t2_stall_stable", 64'(stall_bad), 64'd0);
    o0 = ovr_cnt;
    send_byte(8'h3C);
    cycles(3);
    check("t6_overrun_wait_out", 64'(ovr_cnt - o0), 64'd1);
    dec_beats.delete();
    repeat (6 * 8 / SYM) dec_beats.push_back(SYM'($urandom));
    low0 = core_low;
    send_decoded(1'b1);
    check_pack("t5");
    if (owords_q.size() > 1) check("t5_word1_upper_zero", 64'(owords_q[1][31:16]), 64'd0);
    finish_frame("t5", low0);

    // Overrun during FEED, then async reset mid-FEED.
    random_frame();
    beats_q.delete();
    ready_mode = 0;
    foreach (frame_bytes[i]) send_byte(frame_bytes[i]);
    c = 0;
    while (!dec_if.dec_in_valid && c < 100) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("t6_feed_started", 64'(dec_if.dec_in_valid), 64'd1);
    o0 = ovr_cnt;
    send_byte(8'hFF);
    cycles(3);
    check("t6_overrun_feed", 64'(ovr_cnt - o0), 64'd1);
    ready_mode = 3;
    wait_beats(100, "t6");
    dec_beats.delete();
    repeat (3) dec_beats.push_back(SYM'($urandom));
    send_decoded(1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(dec_if.dec_in_valid), 64'd0);
    check("t6_rst_sop_eop", 64'({dec_if.dec_in_sop, dec_if.dec_in_eop}), 64'd0);
    check("t6_rst_data", 64'(dec_if.dec_in_data), 64'd0);
    check("t6_rst_core", 64'(core_rst_n), 64'd0);
    check("t6_rst_byte_out", 64'(byte_out), 64'd0);
    cycles(3);
    rst_n = 1'b1;
    v0 = valid_cycles;
    cycles(10);
    check("t6_idle_after_rst", 64'(valid_cycles - v0), 64'd0);
    check("t6_no_partial_bytes", 64'(obytes_q.size()), 64'd0);
    check("t6_core_rst_n", 64'(core_rst_n), 64'd1);

    // Recovery frame with random backpressure and a random-length decoded stream.
    random_frame();
    stall_bad = 0;
    run_feed("t7");
    ready_mode = 1;
    check("t7_stall_stable", 64'(stall_bad), 64'd0);
    dec_beats.delete();
    repeat ($urandom_range(1, 40)) dec_beats.push_back(SYM'($urandom));
    low0 = core_low;
    send_decoded(1'b1);
    check_pack("t7");
    finish_frame("t7", low0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
